// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: fetch PC, single-outstanding imem request port and a
// DEPTH-entry prefetch queue feeding decode through a valid/ready pair.
module if_prefetch_stage #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter logic [ADDR_W-1:0]    PC_STEP  = ADDR_W'(4)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_ref_addr
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WAIT_STALE
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_req_addr;

    logic [DATA_W-1:0]   r_q_instr [DEPTH];
    logic [ADDR_W-1:0]   r_q_ref   [DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_push;
    logic                w_pop;
    logic                w_nonempty;
    logic [CNT_W-1:0]    w_occ_next;
    logic                w_space;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_redir_inc;
    logic [ADDR_W-1:0]   w_ref_wr;

    // Handshake and occupancy terms shared by the FSM and the queue.
    assign w_nonempty  = (r_count != '0);
    assign w_push      = imem_ack && (r_state == S_WAIT) && !redirect;
    assign w_pop       = w_nonempty && out_ready;
    assign w_occ_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_space     = (w_occ_next < DEPTH_C);
    assign w_pc_inc    = r_pc + PC_STEP;
    assign w_redir_inc = redirect_addr + PC_STEP;
    assign w_ref_wr    = r_req_addr + PC_STEP;

    assign imem_req     = (r_state != S_IDLE);
    assign imem_addr    = r_req_addr;
    assign out_valid    = w_nonempty;
    assign out_instr    = w_nonempty ? r_q_instr[r_rd_ptr] : '0;
    assign out_ref_addr = w_nonempty ? r_q_ref[r_rd_ptr]   : '0;

    // Fetch FSM: issues one request at a time and tracks stale responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (redirect) begin
                        r_pc       <= redirect_addr;
                        r_req_addr <= redirect_addr;
                        r_state    <= S_WAIT;
                    end else if (w_space) begin
                        r_req_addr <= r_pc;
                        r_pc       <= w_pc_inc;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect && imem_ack) begin
                        r_pc       <= w_redir_inc;
                        r_req_addr <= redirect_addr;
                    end else if (redirect) begin
                        // Request must stay held; its answer is dropped.
                        r_pc    <= redirect_addr;
                        r_state <= S_WAIT_STALE;
                    end else if (imem_ack) begin
                        if (w_space) begin
                            r_req_addr <= r_pc;
                            r_pc       <= w_pc_inc;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WAIT_STALE: begin
                    if (imem_ack && redirect) begin
                        r_pc       <= w_redir_inc;
                        r_req_addr <= redirect_addr;
                        r_state    <= S_WAIT;
                    end else if (imem_ack) begin
                        r_req_addr <= r_pc;
                        r_pc       <= w_pc_inc;
                        r_state    <= S_WAIT;
                    end else if (redirect) begin
                        r_pc <= redirect_addr;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Queue pointers and occupancy; redirect flushes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_occ_next;
        end
    end

    // Queue storage; contents are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_ref[r_wr_ptr]   <= w_ref_wr;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb_if_prefetch_stage: directed checks of fetch sequencing, back-pressure,
// slow memory, redirects and 8-bit address wrap.
module tb_if_prefetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_ref_addr;

    logic        redirect8 = 1'b0;
    logic [7:0]  redirect_addr8 = '0;
    logic        imem_req8;
    logic [7:0]  imem_addr8;
    logic        imem_ack8 = 1'b1;
    logic [31:0] imem_rdata8;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [31:0] out_instr8;
    logic [7:0]  out_ref8;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign imem_rdata  = imem_addr ^ 32'hDEAD_0000;
    assign imem_rdata8 = {24'hC0DE00, imem_addr8};

    if_prefetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_ref_addr (out_ref_addr)
    );

    if_prefetch_stage #(
        .ADDR_W  (8),
        .DATA_W  (32),
        .DEPTH   (4),
        .RESET_PC(8'hF8),
        .PC_STEP (8'h04)
    ) dut8 (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect8),
        .redirect_addr(redirect_addr8),
        .imem_req     (imem_req8),
        .imem_addr    (imem_addr8),
        .imem_ack     (imem_ack8),
        .imem_rdata   (imem_rdata8),
        .out_valid    (out_valid8),
        .out_ready    (out_ready8),
        .out_instr    (out_instr8),
        .out_ref_addr (out_ref8)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_ref", 64'(out_ref_addr), 64'd0);
        redirect  = 1'b0;
        imem_ack  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Streaming with zero-wait memory, plus the 8-bit wrap instance.
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("s_req", 64'(imem_req), 64'd1);
        chk("s_addr0", 64'(imem_addr), 64'h0);
        chk("s_valid0", 64'(out_valid), 64'd0);
        chk("w_addr0", 64'(imem_addr8), 64'hF8);
        step();
        chk("s_addr1", 64'(imem_addr), 64'h4);
        chk("s_instr1", 64'(out_instr), 64'hDEAD0000);
        chk("s_ref1", 64'(out_ref_addr), 64'h4);
        chk("w_addr1", 64'(imem_addr8), 64'hFC);
        chk("w_ref1", 64'(out_ref8), 64'hFC);
        chk("w_instr1", 64'(out_instr8), 64'hC0DE00F8);
        step();
        chk("s_addr2", 64'(imem_addr), 64'h8);
        chk("s_instr2", 64'(out_instr), 64'hDEAD0004);
        chk("s_ref2", 64'(out_ref_addr), 64'h8);
        chk("w_addr2", 64'(imem_addr8), 64'h00);
        chk("w_ref2", 64'(out_ref8), 64'h00);
        chk("w_instr2", 64'(out_instr8), 64'hC0DE00FC);
        step();
        chk("s_addr3", 64'(imem_addr), 64'hC);
        chk("s_ref3", 64'(out_ref_addr), 64'hC);
        chk("w_addr3", 64'(imem_addr8), 64'h04);
        chk("w_ref3", 64'(out_ref8), 64'h04);

        // Back-pressure: fill four entries, stall, then drain.
        do_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("f_req_drop", 64'(imem_req), 64'd0);
        chk("f_valid", 64'(out_valid), 64'd1);
        chk("f_head", 64'(out_ref_addr), 64'h4);
        step();
        chk("f_req_idle", 64'(imem_req), 64'd0);
        out_ready = 1'b1;
        step();
        chk("f_resume_req", 64'(imem_req), 64'd1);
        chk("f_resume_addr", 64'(imem_addr), 64'h10);
        chk("f_pop1", 64'(out_ref_addr), 64'h8);
        step();
        chk("f_pop2", 64'(out_ref_addr), 64'hC);
        chk("f_pop2_instr", 64'(out_instr), 64'hDEAD0008);
        step();
        chk("f_pop3", 64'(out_ref_addr), 64'h10);
        step();
        chk("f_pop4", 64'(out_ref_addr), 64'h14);
        chk("f_pop4_instr", 64'(out_instr), 64'hDEAD0010);

        // Slow memory: ack arrives in the third cycle of each request.
        do_reset();
        out_ready = 1'b1;
        step();
        chk("l_addr_c1", 64'(imem_addr), 64'h0);
        step();
        chk("l_addr_c2", 64'(imem_addr), 64'h0);
        chk("l_req_c2", 64'(imem_req), 64'd1);
        step();
        chk("l_addr_c3", 64'(imem_addr), 64'h0);
        chk("l_valid_c3", 64'(out_valid), 64'd0);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("l_valid_a", 64'(out_valid), 64'd1);
        chk("l_instr_a", 64'(out_instr), 64'hDEAD0000);
        chk("l_addr_a", 64'(imem_addr), 64'h4);
        step();
        chk("l_valid_b", 64'(out_valid), 64'd0);
        chk("l_addr_b", 64'(imem_addr), 64'h4);
        step();
        chk("l_addr_c", 64'(imem_addr), 64'h4);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("l_ref_d", 64'(out_ref_addr), 64'h8);
        chk("l_addr_d", 64'(imem_addr), 64'h8);

        // Redirect while the request to 0x8 is outstanding.
        do_reset();
        imem_ack = 1'b1;
        step();
        step();
        step();
        imem_ack = 1'b0;
        step();
        chk("r_pend_addr", 64'(imem_addr), 64'h8);
        chk("r_pre_valid", 64'(out_valid), 64'd1);
        redirect      = 1'b1;
        redirect_addr = 32'h100;
        step();
        redirect = 1'b0;
        chk("r_flush", 64'(out_valid), 64'd0);
        chk("r_hold_addr", 64'(imem_addr), 64'h8);
        chk("r_hold_req", 64'(imem_req), 64'd1);
        imem_ack = 1'b1;
        step();
        chk("r_stale_drop", 64'(out_valid), 64'd0);
        chk("r_new_addr", 64'(imem_addr), 64'h100);
        out_ready = 1'b1;
        step();
        chk("r_first_valid", 64'(out_valid), 64'd1);
        chk("r_first_ref", 64'(out_ref_addr), 64'h104);
        chk("r_first_instr", 64'(out_instr), 64'hDEAD0100);

        // Redirect coincident with ack and pop.
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        chk("c_pre_valid", 64'(out_valid), 64'd1);
        redirect      = 1'b1;
        redirect_addr = 32'h200;
        step();
        redirect = 1'b0;
        chk("c_empty", 64'(out_valid), 64'd0);
        chk("c_addr", 64'(imem_addr), 64'h200);
        chk("c_req", 64'(imem_req), 64'd1);
        step();
        chk("c_valid", 64'(out_valid), 64'd1);
        chk("c_ref", 64'(out_ref_addr), 64'h204);
        chk("c_instr", 64'(out_instr), 64'hDEAD0200);
        chk("c_next_addr", 64'(imem_addr), 64'h204);

        // Asynchronous reset in the middle of a request.
        rst = 1'b1;
        #1;
        chk("a_req", 64'(imem_req), 64'd0);
        chk("a_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
